// File: rtl/chess_pkg.sv
// Shared board geometry, square codes and move encoding for the chess display engine.
package chess_pkg;

  localparam int CHESS_SQUARES = 64;
  localparam int SQUARE_WIDTH  = 4;
  localparam int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH;
  localparam int BOARD_ROWS    = 8;
  localparam int BOARD_COLS    = 8;

  localparam logic [3:0] SQ_EMPTY  = 4'h0;
  localparam logic [3:0] SQ_MARKER = 4'h1;

  typedef enum logic [2:0] {
    MOVE_NONE,
    MOVE_LEFT,
    MOVE_RIGHT,
    MOVE_UP,
    MOVE_DOWN
  } moveDir_t;

  // Simultaneous presses resolve Left > Right > Up > Down; losers are dropped.
  function automatic moveDir_t pickMove(input logic pressLeft, input logic pressRight,
                                        input logic pressUp, input logic pressDown);
    moveDir_t move;
    move = MOVE_NONE;
    if (pressLeft)       move = MOVE_LEFT;
    else if (pressRight) move = MOVE_RIGHT;
    else if (pressUp)    move = MOVE_UP;
    else if (pressDown)  move = MOVE_DOWN;
    return move;
  endfunction

endpackage

// File: rtl/chess_layout_matrix_key_debounce.sv
// Active-low key conditioner: two-flop synchronizer, stability counter and
// a one-cycle press pulse on each debounced released-to-pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetApp,
  input  logic keyN,
  output logic pressEvent
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncA;
  logic          syncB;
  logic          level;
  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) begin
      syncA      <= 1'b1;
      syncB      <= 1'b1;
      level      <= 1'b1;
      count      <= '0;
      pressEvent <= 1'b0;
    end else begin
      syncA      <= keyN;
      syncB      <= syncA;
      pressEvent <= 1'b0;
      // Any sample matching the accepted level breaks the run of differing samples.
      if (syncB == level) begin
        count <= '0;
      end else if (count == COUNT_LAST) begin
        count      <= '0;
        level      <= syncB;
        pressEvent <= ~syncB;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chess_layout_matrix.sv
// Board-state top: debounces four keys, moves a single marker with wraparound
// and decodes the cursor into the packed per-square code matrix.
module chess_layout_matrix #(
  parameter int CHESS_SQUARES   = 64,
  parameter int SQUARE_WIDTH    = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int START_SQUARE    = 0
) (
  input  logic                                  clock,
  input  logic                                  resetApp,
  input  logic                                  KeyLeft,
  input  logic                                  KeyUp,
  input  logic                                  KeyDown,
  input  logic                                  KeyRight,
  output logic [CHESS_SQUARES*SQUARE_WIDTH-1:0] Matrix
);

  import chess_pkg::*;

  localparam logic [2:0] START_ROW = 3'(START_SQUARE / BOARD_COLS);
  localparam logic [2:0] START_COL = 3'(START_SQUARE % BOARD_COLS);

  logic     pressLeft;
  logic     pressRight;
  logic     pressUp;
  logic     pressDown;
  logic [2:0] cursorRow;
  logic [2:0] cursorCol;
  moveDir_t move;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLeft (
    .clock(clock), .resetApp(resetApp), .keyN(KeyLeft), .pressEvent(pressLeft)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRight (
    .clock(clock), .resetApp(resetApp), .keyN(KeyRight), .pressEvent(pressRight)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUp (
    .clock(clock), .resetApp(resetApp), .keyN(KeyUp), .pressEvent(pressUp)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDown (
    .clock(clock), .resetApp(resetApp), .keyN(KeyDown), .pressEvent(pressDown)
  );

  assign move = pickMove(pressLeft, pressRight, pressUp, pressDown);

  // Wraparound on the 8x8 board falls out of 3-bit modular arithmetic.
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) begin
      cursorRow <= START_ROW;
      cursorCol <= START_COL;
    end else begin
      unique case (move)
        MOVE_LEFT:  cursorCol <= cursorCol - 3'd1;
        MOVE_RIGHT: cursorCol <= cursorCol + 3'd1;
        MOVE_UP:    cursorRow <= cursorRow - 3'd1;
        MOVE_DOWN:  cursorRow <= cursorRow + 3'd1;
        default:    ;
      endcase
    end
  end

  always_comb begin
    Matrix = '0;
    for (int unsigned i = 0; i < CHESS_SQUARES; i++) begin
      Matrix[i*SQUARE_WIDTH +: SQUARE_WIDTH] =
        (i == 32'({cursorRow, cursorCol})) ? SQUARE_WIDTH'(SQ_MARKER) : SQUARE_WIDTH'(SQ_EMPTY);
    end
  end

endmodule

// File: tb/tb_chess_layout_matrix.sv
// Directed and randomized checks of the chess board-state block against a square-number model.
module tb_chess_layout_matrix;

  localparam int D = 4;

  logic         clock;
  logic         resetApp;
  logic         kL, kR, kU, kD;
  logic [255:0] Matrix;

  int checks = 0;
  int errors = 0;
  int sq;

  chess_layout_matrix #(
    .CHESS_SQUARES(64),
    .SQUARE_WIDTH(4),
    .DEBOUNCE_CYCLES(D),
    .START_SQUARE(0)
  ) dut (
    .clock(clock),
    .resetApp(resetApp),
    .KeyLeft(kL),
    .KeyUp(kU),
    .KeyDown(kD),
    .KeyRight(kR),
    .Matrix(Matrix)
  );

  always #5 clock = ~clock;

  function automatic logic [255:0] expMatrix(input int s);
    logic [255:0] m;
    m = 256'h1;
    return m << (s * 4);
  endfunction

  // mask bits: 0 Left, 1 Right, 2 Up, 3 Down
  function automatic int modelMove(input int s, input logic [3:0] mask);
    int row, col;
    row = s / 8;
    col = s % 8;
    if (mask[0])      col = (col + 7) % 8;
    else if (mask[1]) col = (col + 1) % 8;
    else if (mask[2]) row = (row + 7) % 8;
    else if (mask[3]) row = (row + 1) % 8;
    return row * 8 + col;
  endfunction

  task automatic setKeys(input logic [3:0] pressed);
    kL = ~pressed[0];
    kR = ~pressed[1];
    kU = ~pressed[2];
    kD = ~pressed[3];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkSq(input string tag, input int s);
    logic [255:0] e;
    e = expMatrix(s);
    checks++;
    assert (Matrix === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, Matrix, e);
    end
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    setKeys(mask);
    tick(hold);
    setKeys(4'b0000);
    tick(12);
  endtask

  task automatic doReset();
    resetApp = 1'b0;
    tick(2);
    resetApp = 1'b1;
    tick(2);
    sq = 0;
  endtask

  initial begin
    clock    = 1'b0;
    resetApp = 1'b0;
    setKeys(4'b0000);
    sq = 0;

    tick(2);
    checkSq("reset_value", 0);
    resetApp = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checkSq("idle_stable", 0);
    end

    press(4'b0010, 12);
    checkSq("right_once", 1);
    press(4'b0010, 50);
    checkSq("right_held_once", 2);

    doReset();
    press(4'b0001, 12);
    checkSq("wrap_left", 7);
    press(4'b0100, 12);
    checkSq("wrap_up", 63);
    press(4'b1000, 12);
    checkSq("wrap_down", 7);

    press(4'b1000, 2);
    checkSq("glitch_short", 7);
    for (int i = 0; i < 14; i++) begin
      kD = ~kD;
      tick(3);
    end
    kD = 1'b1;
    tick(12);
    checkSq("glitch_toggle", 7);

    doReset();
    press(4'b1001, 50);
    checkSq("simul_left_down", 7);
    press(4'b1000, 12);
    checkSq("down_after_simul", 15);

    // press-to-move latency window around DEBOUNCE_CYCLES+3
    doReset();
    setKeys(4'b0010);
    tick(D + 1);
    checkSq("latency_early", 0);
    tick(3);
    checkSq("latency_late", 1);
    setKeys(4'b0000);
    tick(12);

    press(4'b1000, 12);
    checkSq("reach_nine", 9);
    setKeys(4'b0010);
    tick(3);
    resetApp = 1'b0;
    #1;
    checkSq("reset_async_mid_press", 0);
    tick(3);
    checkSq("reset_held", 0);
    resetApp = 1'b1;
    tick(20);
    checkSq("held_through_reset", 1);
    tick(30);
    checkSq("held_no_repeat", 1);
    setKeys(4'b0000);
    tick(12);
    checkSq("held_release", 1);

    doReset();
    for (int it = 0; it < 40; it++) begin
      logic [3:0] mask;
      if ($urandom_range(0, 3) == 0) begin
        mask = 4'($urandom_range(1, 15));
        press(mask, $urandom_range(1, 2));
        checkSq("rand_glitch", sq);
      end else begin
        mask = 4'($urandom_range(0, 15));
        press(mask, $urandom_range(8, 30));
        sq = modelMove(sq, mask);
        checkSq("rand_press", sq);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chess_layout_matrix.md
# chess_layout_matrix

Board-state block of the chess display engine. It conditions four active-low push-button keys and moves a single marker piece around the 8×8 board. It presents the board as a packed 64-square × 4-bit matrix that the pixel engine samples every pixel to choose square sprites.

## Interface
Parameters:
- `CHESS_SQUARES`, 64: number of board squares.
- `SQUARE_WIDTH`, 4: bits per square code.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples needed to accept a key level (10 ms at 50 MHz).
- `START_SQUARE`, 0: marker square after reset (0..63).

Ports:
- `clock`  in  1  system clock; all state on its rising edge.
- `resetApp`  in  1  one clock; reset is asynchronous and active-low (asserted at 0).
- `KeyLeft`  in  1  active-low, asynchronous push-button.
- `KeyUp`  in  1  active-low, asynchronous push-button.
- `KeyDown`  in  1  active-low, asynchronous push-button.
- `KeyRight`  in  1  active-low, asynchronous push-button.
- `Matrix`  out  `CHESS_SQUARES*SQUARE_WIDTH` (256)  board codes. Square `i` occupies `Matrix[4i+3:4i]`. `i = row*8 + col`, with row 0 at the top (just below the clock banner) and col 0 at the left.

## Operation
- Square codes: 4'h0 = empty; 4'h1 = marker (rendered as a dark chessman). Codes 2–F are reserved and never driven.
- Internal state is a cursor `(row, col)`, 3 bits each. `Matrix` is a pure decode of the cursor: the cursor square is 4'h1 and all 63 others are 4'h0.
- Per key:
  - two-flop synchronizer;
  - debounce counter: the debounced level changes only after `DEBOUNCE_CYCLES` consecutive identical synchronized samples that differ from the current level; any differing sample restarts the count;
  - a press event is the debounced falling transition (released→pressed).
- Moves:
  - Left: col−1, wrapping 0→7, same row.
  - Right: col+1, wrapping 7→0.
  - Up: row−1, wrapping 0→7, same column.
  - Down: row+1, wrapping 7→0.
- One move per press. No auto-repeat while held. A release must also pass debounce before the next press counts.
- Simultaneous press events in the same cycle: priority Left > Right > Up > Down. Only the winner moves; the others are discarded, not deferred.
- Reset:
  - cursor = `START_SQUARE`;
  - synchronizer flops and debounced levels = released (1);
  - counters = 0.
- A key held through reset release produces exactly one press after debounce.

## Timing
- `Matrix` reset value: code 1 at `START_SQUARE`, 0 elsewhere. It is valid asynchronously during reset.
- Input low is stable from edge N:
  - the synchronized value is valid at N+2;
  - the debounced level changes at N+2+`DEBOUNCE_CYCLES`;
  - the cursor and `Matrix` update on the next edge.
  - Total latency is `DEBOUNCE_CYCLES`+3 cycles, ±1 for input sampling phase.
- `Matrix` changes at most once per clock and only on a press event. It is glitch-free relative to `clock` because it is decoded from registers only.
- Asserting reset mid-debounce or mid-press aborts all pending events immediately.

## Structure
- Shared package `chess_pkg`:
  - `CHESS_SQUARES`, `SQUARE_WIDTH`, `MATRIX_WIDTH`;
  - square-code constants `SQ_EMPTY` = 4'h0, `SQ_MARKER` = 4'h1;
  - board geometry (8 rows, 8 columns).
- One sub-module, `key_debounce`: synchronizer, debounce counter and press-event output, instantiated four times with `DEBOUNCE_CYCLES` passed through.
- The top level holds the cursor registers, the priority move logic and the matrix decode.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `START_SQUARE`=0.
- Reset asserted (0) then released with keys high → `Matrix` = 256'h1 (square 0 = 1). No change over 100 cycles.
- KeyRight low for 12 cycles, then high for 12 → `Matrix[7:4]`=1 and all other nibbles 0. Holding low for 50 cycles still moves only once.
- Wrap checks, each from square 0:
  - KeyLeft press → square 7.
  - Then KeyUp press → square 63.
  - Then KeyDown press → square 7.
- KeyDown low for 2 cycles (a glitch shorter than debounce) → `Matrix` unchanged. Toggling every 3 cycles for 40 cycles → unchanged.
- KeyLeft and KeyDown pulled low in the same cycle from square 0 → square 7 only. Holding both for 50 cycles produces no further moves; releasing then pressing KeyDown alone → square 15.
- Cursor moved to square 9, then reset asserted mid-press → `Matrix` returns to 256'h1 immediately (asynchronously). A key still held at reset release gives exactly one move after debounce.
